mont_mul_radix2: RTL and testbench

Bit-serial radix-2 Montgomery multiplier computing result = in_a · in_b · 2^-WIDTH mod in_m. It is the arithmetic core directly downstream of the exponentiation controller's operand multiplexer. The controller starts two instances in the same cycle, one for squaring and one for multiplying, and pairs their done pulses. Every operation therefore has fixed, data-independent latency.

---
 rtl/mont_mul_radix2.sv | 94 +++++++++
 tb/tb_mont_mul_radix2.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = in_a * in_b * 2^-WIDTH mod in_m.
// Fixed latency of WIDTH+2 cycles from the start edge to the done pulse, independent of data.
module mont_mul_radix2 #(
  parameter int WIDTH = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOOP = 2'd1,
    S_SUB  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q, m_q;
  logic [WIDTH+1:0] c_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH+1:0] b_ext, m_ext, t_add, t_red, c_sub;
  logic             last_iter;

  // C stays below 2M, so every intermediate fits in WIDTH+2 bits without loss.
  always_comb begin
    b_ext     = {2'b00, b_q};
    m_ext     = {2'b00, m_q};
    t_add     = c_q + (a_q[cnt_q] ? b_ext : '0);
    t_red     = t_add + (t_add[0] ? m_ext : '0);
    c_sub     = c_q - m_ext;
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_LOOP;
      S_LOOP: if (last_iter) state_nx = S_SUB;
      S_SUB:  state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      c_q    <= '0;
      cnt_q  <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nx;
      // done is registered from DONE so it lands WIDTH+2 cycles after the start edge.
      done  <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= in_a;
            b_q   <= in_b;
            m_q   <= in_m;
            c_q   <= '0;
            cnt_q <= '0;
          end
        end
        S_LOOP: begin
          c_q   <= t_red >> 1;
          cnt_q <= cnt_q + CW'(1);
        end
        S_SUB: begin
          result <= (c_q >= m_ext) ? c_sub[WIDTH-1:0] : c_q[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  // busy covers the done cycle, during which the FSM is already back in IDLE and may accept.
  assign busy      = (state != S_IDLE) | done;
  assign state_dbg = state;

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Bench for mont_mul_radix2: directed and random 8-bit cases, back-to-back and reset abort,
// plus paired 1024-bit instances checked against a REDC-formula reference.
module tb_mont_mul_radix2;

  localparam int W8 = 8;
  localparam int WK = 1024;
  localparam int NUM_RAND8 = 16;
  localparam int NUM_RAND1K = 30;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 8-bit instance
  logic          start8 = 1'b0;
  logic [W8-1:0] in_a8 = '0, in_b8 = '0, in_m8 = '0;
  logic [W8-1:0] result8;
  logic          done8, busy8;
  logic [1:0]    state8;

  mont_mul_radix2 #(.WIDTH(W8)) u8 (
    .clk(clk), .reset(reset), .start(start8),
    .in_a(in_a8), .in_b(in_b8), .in_m(in_m8),
    .result(result8), .done(done8), .busy(busy8), .state_dbg(state8)
  );

  // paired 1024-bit instances: u0 multiplies a*b, u1 squares a
  logic          start1k = 1'b0;
  logic [WK-1:0] in_a1k = '0, in_b1k = '0, in_m1k = '0;
  logic [WK-1:0] result0, result1;
  logic          done0, busy0, done1, busy1;
  logic [1:0]    state0, state1;

  mont_mul_radix2 #(.WIDTH(WK)) u_mul (
    .clk(clk), .reset(reset), .start(start1k),
    .in_a(in_a1k), .in_b(in_b1k), .in_m(in_m1k),
    .result(result0), .done(done0), .busy(busy0), .state_dbg(state0)
  );

  mont_mul_radix2 #(.WIDTH(WK)) u_sqr (
    .clk(clk), .reset(reset), .start(start1k),
    .in_a(in_a1k), .in_b(in_a1k), .in_m(in_m1k),
    .result(result1), .done(done1), .busy(busy1), .state_dbg(state1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [WK-1:0] got, input logic [WK-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference models
  function automatic logic [W8-1:0] ref8(input int a, input int b, input int m);
    int x;
    x = (a * b) % m;
    for (int r = 0; r < m; r++)
      if (((r * 256) % m) == x) return W8'(r);
    return '0;
  endfunction

  function automatic logic [WK-1:0] ref1k(input logic [WK-1:0] a, input logic [WK-1:0] b,
                                          input logic [WK-1:0] m);
    logic [WK-1:0]   inv, k, lo;
    logic [2*WK+1:0] p, t, mw;
    inv = m;
    repeat (10) inv = inv * (1024'd2 - m * inv);
    mw = {1026'd0, m};
    p  = {1026'd0, a} * {1026'd0, b};
    lo = p[WK-1:0];
    k  = (1024'd0 - lo) * inv;
    t  = (p + {1026'd0, k} * mw) >> WK;
    if (t >= mw) t = t - mw;
    return t[WK-1:0];
  endfunction

  function automatic logic [WK-1:0] rand1k();
    logic [WK-1:0] v;
    for (int i = 0; i < WK / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // scoreboards
  logic [W8-1:0] exp_q8[$];
  logic [WK-1:0] exp_q0[$];
  logic [WK-1:0] exp_q1[$];

  always @(negedge clk) begin
    if (done8) begin
      if (exp_q8.size() == 0) check("sb8_spurious_done", WK'(done8), '0);
      else check("sb8_result", WK'(result8), WK'(exp_q8.pop_front()));
    end
    if (done0) begin
      if (exp_q0.size() == 0) check("sb_mul_spurious_done", WK'(done0), '0);
      else check("sb_mul_result", result0, exp_q0.pop_front());
    end
    if (done1) begin
      if (exp_q1.size() == 0) check("sb_sqr_spurious_done", WK'(done1), '0);
      else check("sb_sqr_result", result1, exp_q1.pop_front());
    end
  end

  // driver tasks (called at #1 after a rising edge)
  task automatic run8(input int a, input int b, input int m, output int lat, output logic busy_e1);
    in_a8 = W8'(a); in_b8 = W8'(b); in_m8 = W8'(m);
    exp_q8.push_back(ref8(a, b, m));
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = -1;
    busy_e1 = 1'b0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (n == 1) busy_e1 = busy8;
      if (done8) lat = n;
    end
  endtask

  task automatic run1k(input logic [WK-1:0] a, input logic [WK-1:0] b, input logic [WK-1:0] m,
                       output int lat0, output int lat1);
    in_a1k = a; in_b1k = b; in_m1k = m;
    exp_q0.push_back(ref1k(a, b, m));
    exp_q1.push_back(ref1k(a, a, m));
    start1k = 1'b1;
    @(posedge clk); #1;
    start1k = 1'b0;
    lat0 = -1;
    lat1 = -1;
    for (int n = 1; n <= 1100 && (lat0 < 0 || lat1 < 0); n++) begin
      @(posedge clk); #1;
      if (done0 && lat0 < 0) lat0 = n;
      if (done1 && lat1 < 0) lat1 = n;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat, lat0, lat1, a, b, m, low_run, max_low, done_cnt, busy_cnt;
    logic busy_e1;
    int done_edges[$];

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", WK'(result8), '0);
    check("reset_done", WK'(done8), '0);
    check("reset_busy", WK'(busy8), '0);
    check("reset_busy_1k", WK'(busy0 | busy1), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run8(8'h11, 8'h01, 8'hEF, lat, busy_e1);
    check("t1_busy_edge1", WK'(busy_e1), WK'(1));
    check("t1_latency", WK'(lat), WK'(10));
    @(posedge clk); #1;
    check("t1_done_one_cycle", WK'(done8), '0);
    check("t1_result_held", WK'(result8), WK'(8'h01));

    run8(8'hEE, 8'hEE, 8'hEF, lat, busy_e1);
    check("t2_latency", WK'(lat), WK'(10));
    @(posedge clk); #1;
    check("t2_result_held", WK'(result8), WK'(8'hE1));

    run8(0, 0, 8'hEF, lat, busy_e1);
    check("t3_latency_zero", WK'(lat), WK'(10));
    @(posedge clk); #1;

    for (int i = 0; i < NUM_RAND8; i++) begin
      m = $urandom_range(3, 255) | 1;
      a = $urandom_range(0, m - 1);
      b = $urandom_range(0, m - 1);
      run8(a, b, m, lat, busy_e1);
      check("rand8_latency", WK'(lat), WK'(10));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;

    // start held high for 30 cycles: accepts at edges 0, 11, 22
    in_a8 = 8'h5A; in_b8 = 8'h33; in_m8 = 8'hEF;
    repeat (3) exp_q8.push_back(ref8(8'h5A, 8'h33, 8'hEF));
    start8 = 1'b1;
    low_run = 0;
    max_low = 0;
    for (int n = 0; n <= 44; n++) begin
      @(posedge clk); #1;
      if (n == 29) start8 = 1'b0;
      if (done8) done_edges.push_back(n);
      if (n <= 32) begin
        if (!busy8) low_run++;
        else low_run = 0;
        if (low_run > max_low) max_low = low_run;
      end
    end
    check("held_done_count", WK'(done_edges.size()), WK'(3));
    for (int i = 0; i < 3; i++)
      check("held_done_edge", WK'((i < done_edges.size()) ? done_edges[i] : -1), WK'(10 + 11 * i));
    check("held_busy_gap_le1", WK'(max_low <= 1), WK'(1));

    // reset in the 4th LOOP cycle, with a start that must be dropped
    in_a8 = 8'h77; in_b8 = 8'h42; in_m8 = 8'hEF;
    start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    start8 = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    start8 = 1'b0;
    check("rst_done", WK'(done8), '0);
    check("rst_busy", WK'(busy8), '0);
    check("rst_result", WK'(result8), '0);
    done_cnt = 0;
    busy_cnt = 0;
    for (int n = 0; n < 14; n++) begin
      @(posedge clk); #1;
      if (done8) done_cnt++;
      if (busy8) busy_cnt++;
    end
    check("rst_no_partial_done", WK'(done_cnt), '0);
    check("rst_start_dropped", WK'(busy_cnt), '0);
    run8(8'h77, 8'h42, 8'hEF, lat, busy_e1);
    check("rst_restart_latency", WK'(lat), WK'(10));
    @(posedge clk); #1;

    // paired 1024-bit instances
    for (int i = 0; i < NUM_RAND1K; i++) begin
      logic [WK-1:0] rm, ra, rb;
      rm = rand1k();
      rm[WK-1] = 1'b1;
      rm[0] = 1'b1;
      ra = rand1k();
      rb = rand1k();
      if (ra >= rm) ra = ra - rm;
      if (rb >= rm) rb = rb - rm;
      run1k(ra, rb, rm, lat0, lat1);
      check("k_mul_latency", WK'(lat0), WK'(1026));
      check("k_pair_same_cycle", WK'(lat1), WK'(lat0));
      @(posedge clk); #1;
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb8_drained", WK'(exp_q8.size()), '0);
    check("sb_mul_drained", WK'(exp_q0.size()), '0);
    check("sb_sqr_drained", WK'(exp_q1.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
